mem_array_rw: RTL and testbench
===============================

# mem_array_rw

- Parametrised, writable successor to the fixed-size, read-only `_memArray` grid.
- Stores a ROWS × COLS array of WIDTH-bit cells.
- Provides one synchronous write port and one registered read port.
- After every reset it runs a multi-cycle hardware clear sequence, then reports each read result with a valid strobe and flags out-of-range addresses.

## Interface
Parameters:
- ROWS, default 8: number of rows, 1..256.
- COLS, default 8: number of columns, 1..256.
- WIDTH, default 1: bits per cell, 1..32.
- ROW_BITS, default 3: width of `_row`; must satisfy 2^ROW_BITS ≥ ROWS.
- COL_BITS, default 3: width of `_column`; must satisfy 2^COL_BITS ≥ COLS.

Ports:
- `_clock` in 1: single clock; all state changes on its rising edge.
- `_reset` in 1: synchronous, active-high reset.
- `_row` in ROW_BITS: row address, shared by read and write.
- `_column` in COL_BITS: column address, shared by read and write.
- `_wr_en` in 1: write request.
- `_wr_data` in WIDTH: data to write.
- `_rd_en` in 1: read request.
- `_value` out WIDTH: registered read data.
- `_valid` out 1: one-cycle strobe; `_value` holds a fresh read result.
- `_busy` out 1: clear sequence in progress; requests are ignored while high.
- `_err` out 1: one-cycle strobe; the previous-edge request addressed row ≥ ROWS or column ≥ COLS.

## Operation
- **States:** CLEAR and READY.
- **Reset:** any edge with `_reset`=1 sets the following, regardless of state:
  - state ← CLEAR, clear counter ← 0;
  - `_busy` ← 1, `_value` ← 0, `_valid` ← 0, `_err` ← 0.
  - Memory contents are not touched on reset edges.
- **CLEAR:**
  - Each edge with `_reset`=0 writes zero to every cell of row *counter*, then increments the counter.
  - The edge that clears row ROWS-1 moves the state to READY and sets `_busy` ← 0.
  - `_wr_en` and `_rd_en` are ignored during CLEAR. `_valid` and `_err` stay 0.
- **READY, per edge:**
  - Address in range and `_wr_en`=1: `mem[_row][_column]` ← `_wr_data`.
  - Address in range and `_rd_en`=1: `_value` ← `mem[_row][_column]` and `_valid` ← 1. Otherwise `_valid` ← 0 and `_value` holds its last value.
  - Address out of range with (`_wr_en` | `_rd_en`) = 1:
    - no memory write;
    - `_value` ← 0, `_valid` ← 1 if `_rd_en` else 0;
    - `_err` ← 1.
  - Otherwise `_err` ← 0.
- **Simultaneous read and write to the same cell:** read-before-write. `_value` returns the old contents; the new data is visible to reads on the following edge.
- **Reset in the middle of CLEAR or READY:** the clear restarts from row 0 and runs the full ROWS cycles.
- **Addressing:** row-major internally, index = row·COLS + column. No wrap-around: out-of-range addresses never alias onto valid cells.

## Timing
- Read latency is 1 cycle. A request sampled at edge N produces `_value`/`_valid` after edge N, and they are valid through edge N+1.
- Back-to-back reads every cycle are supported; `_valid` stays high continuously.
- Clear duration: `_busy` falls after exactly ROWS edges with `_reset` low. The first request accepted is the one sampled at edge ROWS+1.
- A write takes effect at the edge it is sampled.
- `_err` and `_valid` are pulses, each high for exactly one cycle per request.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
1. **Clear sequence** (ROWS=8, COLS=8, WIDTH=4).
   - Stimulus: hold `_reset`=1 for 2 edges, release, then assert `_rd_en` at (1,5) continuously.
   - Required: `_busy`=1 for exactly 8 edges, and no `_valid` during that time.
   - Required: first `_valid`=1 has `_value`=0.
2. **Write then read.**
   - Stimulus: write 4'hA to (1,5), 4'h3 to (3,2), 4'hF to (6,0); then read all three back-to-back.
   - Required: `_valid` high for 3 consecutive cycles with `_value` = A, 3, F, each 1 cycle after its request.
3. **Read-before-write.**
   - Stimulus: (2,2) holds 4'h5; in one cycle write 4'h9 to (2,2) with `_rd_en`=1.
   - Required: `_value`=5.
   - Required: a read on the next cycle returns 9.
4. **Out-of-range** (ROWS=6, COLS=5, ROW_BITS=3, COL_BITS=3).
   - Stimulus: write 4'h7 to (6,0) and to (0,5); read (6,0).
   - Required: `_err` pulses on each request; the read gives `_value`=0 with `_valid`=1.
   - Required: cells (0,0) and (1,0) remain 0.
5. **Reset in the middle of clear** (ROWS=8).
   - Stimulus: cell (7,7) holds 4'hC; assert `_reset` at clear edge 4 for 1 cycle.
   - Required: `_busy` stays high for 8 more edges.
   - Required: a subsequent read of (7,7) returns 0.
6. **Requests during busy.**
   - Stimulus: issue a write of 4'h1 to (0,0) during CLEAR.
   - Required: the write is ignored; a read after `_busy` falls returns 0, and `_err` stays 0.

Source files
------------

// File: rtl/mem_array_rw.sv
// ROWS x COLS grid of WIDTH-bit cells with one synchronous write port and one
// registered read port; every reset starts a row-per-cycle hardware clear.
module mem_array_rw #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int WIDTH    = 1,
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 3
) (
  input  logic                _clock,
  input  logic                _reset,
  input  logic [ROW_BITS-1:0] _row,
  input  logic [COL_BITS-1:0] _column,
  input  logic                _wr_en,
  input  logic [WIDTH-1:0]    _wr_data,
  input  logic                _rd_en,
  output logic [WIDTH-1:0]    _value,
  output logic                _valid,
  output logic                _busy,
  output logic                _err
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra bit so ROWS/COLS equal to 2^BITS still compare correctly.
  localparam logic [ROW_BITS:0]   ROWS_L   = (ROW_BITS + 1)'(ROWS);
  localparam logic [COL_BITS:0]   COLS_L   = (COL_BITS + 1)'(COLS);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e               state_q;
  logic [ROW_BITS-1:0]  clr_cnt_q;
  logic [WIDTH-1:0]     value_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 err_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];

  logic                 in_range_s;
  logic                 req_s;
  logic                 wr_ok_s;
  logic [AW-1:0]        idx_s;

  assign in_range_s = ({1'b0, _row} < ROWS_L) && ({1'b0, _column} < COLS_L);
  assign req_s      = _wr_en | _rd_en;
  assign wr_ok_s    = (state_q == ST_READY) && in_range_s && _wr_en;
  // Only meaningful when in_range_s is set, so truncation cannot alias.
  assign idx_s      = AW'(int'(_row) * COLS + int'(_column));

  // Storage: no reset, so contents survive reset edges until the clear reaches them.
  always_ff @(posedge _clock) begin
    if (!_reset) begin
      if (state_q == ST_CLEAR) begin
        for (int c = 0; c < COLS; c++) begin
          mem_q[AW'(int'(clr_cnt_q) * COLS + c)] <= {WIDTH{1'b0}};
        end
      end else if (wr_ok_s) begin
        mem_q[idx_s] <= _wr_data;
      end
    end
  end

  // Control FSM and registered outputs; reads sample storage before this edge's write.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= {ROW_BITS{1'b0}};
      busy_q    <= 1'b1;
      value_q   <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          valid_q <= 1'b0;
          err_q   <= 1'b0;
          if (clr_cnt_q == LAST_ROW) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end else begin
            clr_cnt_q <= clr_cnt_q + {{(ROW_BITS-1){1'b0}}, 1'b1};
          end
        end
        ST_READY: begin
          if (in_range_s) begin
            err_q <= 1'b0;
            if (_rd_en) begin
              value_q <= mem_q[idx_s];
              valid_q <= 1'b1;
            end else begin
              valid_q <= 1'b0;
            end
          end else if (req_s) begin
            value_q <= {WIDTH{1'b0}};
            valid_q <= _rd_en;
            err_q   <= 1'b1;
          end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_CLEAR;
          clr_cnt_q <= {ROW_BITS{1'b0}};
          busy_q    <= 1'b1;
          valid_q   <= 1'b0;
          err_q     <= 1'b0;
        end
      endcase
    end
  end

  assign _value = value_q;
  assign _valid = valid_q;
  assign _busy  = busy_q;
  assign _err   = err_q;

endmodule

// File: tb/tb_mem_array_rw.sv
// Directed bench: an 8x8 instance (A) and a 6x5 instance (B), both 4-bit cells.
module tb_mem_array_rw;

  logic clk;
  int   checks;
  int   failures;

  logic       a_reset, a_wr, a_rd;
  logic [2:0] a_row, a_col;
  logic [3:0] a_wd, a_value;
  logic       a_valid, a_busy, a_err;

  logic       b_reset, b_wr, b_rd;
  logic [2:0] b_row, b_col;
  logic [3:0] b_wd, b_value;
  logic       b_valid, b_busy, b_err;

  mem_array_rw #(.ROWS(8), .COLS(8), .WIDTH(4), .ROW_BITS(3), .COL_BITS(3)) dut_a (
    ._clock(clk), ._reset(a_reset), ._row(a_row), ._column(a_col),
    ._wr_en(a_wr), ._wr_data(a_wd), ._rd_en(a_rd),
    ._value(a_value), ._valid(a_valid), ._busy(a_busy), ._err(a_err)
  );

  mem_array_rw #(.ROWS(6), .COLS(5), .WIDTH(4), .ROW_BITS(3), .COL_BITS(3)) dut_b (
    ._clock(clk), ._reset(b_reset), ._row(b_row), ._column(b_col),
    ._wr_en(b_wr), ._wr_data(b_wd), ._rd_en(b_rd),
    ._value(b_value), ._valid(b_valid), ._busy(b_busy), ._err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_set(input logic wr, input logic rd, input logic [2:0] r,
                       input logic [2:0] c, input logic [3:0] d);
    a_wr = wr; a_rd = rd; a_row = r; a_col = c; a_wd = d;
  endtask

  task automatic b_set(input logic wr, input logic rd, input logic [2:0] r,
                       input logic [2:0] c, input logic [3:0] d);
    b_wr = wr; b_rd = rd; b_row = r; b_col = c; b_wd = d;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    a_reset  = 1'b1;
    b_reset  = 1'b1;
    a_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0);
    b_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0);

    // Reset state after two reset edges
    tick();
    tick();
    chk("rst_a_busy",  32'(a_busy),  32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_a_value", 32'(a_value), 32'd0);
    chk("rst_a_err",   32'(a_err),   32'd0);
    chk("rst_b_busy",  32'(b_busy),  32'd1);

    // Clear sequence on A (continuous read of (1,5)); B ignores a write during clear
    a_reset = 1'b0;
    b_reset = 1'b0;
    a_set(1'b0, 1'b1, 3'd1, 3'd5, 4'h0);
    for (int i = 1; i <= 9; i++) begin
      if (i >= 3 && i <= 5) b_set(1'b1, 1'b0, 3'd0, 3'd0, 4'h1);
      else if (i == 7)      b_set(1'b0, 1'b1, 3'd0, 3'd0, 4'h0);
      else                  b_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0);
      tick();
      chk($sformatf("clr_a_busy_e%0d", i),  32'(a_busy),  (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("clr_a_valid_e%0d", i), 32'(a_valid), (i == 9) ? 32'd1 : 32'd0);
      chk($sformatf("clr_b_busy_e%0d", i),  32'(b_busy),  (i < 6) ? 32'd1 : 32'd0);
      chk($sformatf("clr_b_valid_e%0d", i), 32'(b_valid), (i == 7) ? 32'd1 : 32'd0);
      chk($sformatf("clr_b_err_e%0d", i),   32'(b_err),   32'd0);
      if (i == 9) chk("clr_a_first_value", 32'(a_value), 32'd0);
      if (i == 7) chk("busy_wr_ignored_b00", 32'(b_value), 32'd0);
    end
    b_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0);

    // Write then back-to-back read on A
    a_set(1'b1, 1'b0, 3'd1, 3'd5, 4'hA); tick();
    chk("wr1_valid", 32'(a_valid), 32'd0);
    a_set(1'b1, 1'b0, 3'd3, 3'd2, 4'h3); tick();
    a_set(1'b1, 1'b0, 3'd6, 3'd0, 4'hF); tick();
    chk("wr3_err", 32'(a_err), 32'd0);
    a_set(1'b0, 1'b1, 3'd1, 3'd5, 4'h0); tick();
    chk("rd15_valid", 32'(a_valid), 32'd1);
    chk("rd15_value", 32'(a_value), 32'hA);
    a_set(1'b0, 1'b1, 3'd3, 3'd2, 4'h0); tick();
    chk("rd32_valid", 32'(a_valid), 32'd1);
    chk("rd32_value", 32'(a_value), 32'h3);
    a_set(1'b0, 1'b1, 3'd6, 3'd0, 4'h0); tick();
    chk("rd60_valid", 32'(a_valid), 32'd1);
    chk("rd60_value", 32'(a_value), 32'hF);
    a_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0); tick();
    chk("idle_valid", 32'(a_valid), 32'd0);
    chk("idle_value_hold", 32'(a_value), 32'hF);

    // Read-before-write on (2,2)
    a_set(1'b1, 1'b0, 3'd2, 3'd2, 4'h5); tick();
    a_set(1'b1, 1'b1, 3'd2, 3'd2, 4'h9); tick();
    chk("rbw_valid", 32'(a_valid), 32'd1);
    chk("rbw_old",   32'(a_value), 32'h5);
    a_set(1'b0, 1'b1, 3'd2, 3'd2, 4'h0); tick();
    chk("rbw_new",   32'(a_value), 32'h9);

    // Out-of-range on B (6x5)
    b_set(1'b1, 1'b0, 3'd5, 3'd4, 4'h2); tick();
    chk("oor_inrange_err", 32'(b_err), 32'd0);
    b_set(1'b0, 1'b1, 3'd5, 3'd4, 4'h0); tick();
    chk("oor_pre_value", 32'(b_value), 32'h2);
    b_set(1'b1, 1'b0, 3'd6, 3'd0, 4'h7); tick();
    chk("oor_wr60_err",   32'(b_err),   32'd1);
    chk("oor_wr60_valid", 32'(b_valid), 32'd0);
    chk("oor_wr60_value", 32'(b_value), 32'd0);
    b_set(1'b1, 1'b0, 3'd0, 3'd5, 4'h7); tick();
    chk("oor_wr05_err",   32'(b_err),   32'd1);
    b_set(1'b0, 1'b1, 3'd6, 3'd0, 4'h0); tick();
    chk("oor_rd60_err",   32'(b_err),   32'd1);
    chk("oor_rd60_valid", 32'(b_valid), 32'd1);
    chk("oor_rd60_value", 32'(b_value), 32'd0);
    b_set(1'b0, 1'b1, 3'd0, 3'd0, 4'h0); tick();
    chk("oor_err_pulse",  32'(b_err),   32'd0);
    chk("oor_cell00",     32'(b_value), 32'd0);
    b_set(1'b0, 1'b1, 3'd1, 3'd0, 4'h0); tick();
    chk("oor_cell10",     32'(b_value), 32'd0);
    chk("oor_cell10_vld", 32'(b_valid), 32'd1);
    b_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0);

    // Reset in the middle of clear on A; (7,7) holds C beforehand
    a_set(1'b1, 1'b0, 3'd7, 3'd7, 4'hC); tick();
    a_set(1'b0, 1'b1, 3'd7, 3'd7, 4'h0); tick();
    chk("pre_rst_77", 32'(a_value), 32'hC);
    a_reset = 1'b1; tick();
    chk("rst2_busy",  32'(a_busy),  32'd1);
    chk("rst2_value", 32'(a_value), 32'd0);
    a_reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("pre_restart_busy_e%0d", i), 32'(a_busy), 32'd1);
    end
    a_reset = 1'b1; tick();
    a_reset = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("restart_busy_e%0d", i),  32'(a_busy),  (i < 8) ? 32'd1 : 32'd0);
      chk($sformatf("restart_valid_e%0d", i), 32'(a_valid), (i == 9) ? 32'd1 : 32'd0);
    end
    chk("restart_cell77", 32'(a_value), 32'd0);
    a_set(1'b0, 1'b0, 3'd0, 3'd0, 4'h0); tick();
    chk("final_valid", 32'(a_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
